// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, control-action encoding and helpers for the pipeline control unit.
package arm_pipe_pkg;

   localparam int IF_STG      = 0;
   localparam int ID_STG      = 1;
   localparam int EXE_STG     = 2;
   localparam int FWD_REGFILE = 0;

   typedef enum logic [2:0] {
      ACT_RUN,
      ACT_STALL,
      ACT_FLUSH,
      ACT_BUBBLE,
      ACT_RESET
   } ctrl_act_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for pipe_hazard_ctrl: decode/stage info in, enables/flushes/forwarding out.
interface pipe_hazard_ctrl_if
   import arm_pipe_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int BR_STAGE   = EXE_STG,
   parameter int REG_W      = 4
);
   localparam int FWD_W = $clog2(NUM_STAGES - BR_STAGE);

   logic [REG_W-1:0]            id_src1;
   logic [REG_W-1:0]            id_src2;
   logic                        id_two_src;
   logic                        id_uses_src1;
   logic [NUM_STAGES*REG_W-1:0] stg_dst;
   logic [NUM_STAGES-1:0]       stg_wb_en;
   logic                        exe_mem_read;
   logic                        branch_taken;
   logic                        mem_stall;

   logic [NUM_STAGES-1:0]       stage_en;
   logic [NUM_STAGES-1:0]       stage_flush;
   logic [NUM_STAGES-1:0]       stage_valid;
   logic                        hazard;
   logic [FWD_W-1:0]            fwd_sel1;
   logic [FWD_W-1:0]            fwd_sel2;

   modport master (
      output id_src1, id_src2, id_two_src, id_uses_src1, stg_dst, stg_wb_en,
             exe_mem_read, branch_taken, mem_stall,
      input  stage_en, stage_flush, stage_valid, hazard, fwd_sel1, fwd_sel2
   );

   modport slave (
      input  id_src1, id_src2, id_two_src, id_uses_src1, stg_dst, stg_wb_en,
             exe_mem_read, branch_taken, mem_stall,
      output stage_en, stage_flush, stage_valid, hazard, fwd_sel1, fwd_sel2
   );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Youngest-producer match for one EXE source over stages BR_STAGE+1..NUM_STAGES-1.
module pipe_fwd_match
   import arm_pipe_pkg::*;
#(
   parameter  int NUM_STAGES = 5,
   parameter  int BR_STAGE   = EXE_STG,
   parameter  int REG_W      = 4,
   localparam int FWD_W      = $clog2(NUM_STAGES - BR_STAGE)
) (
   input  logic [REG_W-1:0]            src,
   input  logic                        active,
   input  logic [NUM_STAGES*REG_W-1:0] stg_dst,
   input  logic [NUM_STAGES-1:0]       producer,
   output logic [FWD_W-1:0]            sel
);
   logic unused_low;
   assign unused_low = ^{stg_dst[(BR_STAGE+1)*REG_W-1:0], producer[BR_STAGE:0]};

   // Scan oldest to youngest so the youngest match is the one that sticks.
   always_comb begin
      sel = FWD_W'(FWD_REGFILE);
      if (active) begin
         for (int unsigned i = NUM_STAGES - 1; i > BR_STAGE; i--) begin
            if (producer[i] && (stg_dst[i*REG_W +: REG_W] == src))
               sel = FWD_W'(i - BR_STAGE);
         end
      end
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Unified pipeline freeze/flush/hazard/forwarding control.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import arm_pipe_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int BR_STAGE   = EXE_STG,
   parameter int REG_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              forwarding_en,
   pipe_hazard_ctrl_if.slave bus,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       hazard_cnt,
   output logic [31:0]       flush_cnt
);
   localparam int FWD_W = $clog2(NUM_STAGES - BR_STAGE);

   logic [NUM_STAGES-1:0] valid_q;
   logic [NUM_STAGES-1:0] producer;
   logic [NUM_STAGES-1:0] en;
   logic [NUM_STAGES-1:0] flush;
   logic [REG_W-1:0]      exe_src1, exe_src2;
   logic                  exe_use1, exe_use2;
   logic                  hazard_raw, branch_apply;
   logic [FWD_W-1:0]      sel1, sel2;
   ctrl_act_e             act;

   assign producer     = valid_q & bus.stg_wb_en;
   assign branch_apply = bus.branch_taken & valid_q[BR_STAGE];

   // With forwarding only a load in EXE stalls ID; without it any producer up to MEM does.
   always_comb begin : hazard_detect
      logic [REG_W-1:0] dst;
      logic             hit;
      hazard_raw = 1'b0;
      dst        = '0;
      hit        = 1'b0;
      if (!rst && valid_q[ID_STG] && !branch_apply) begin
         for (int unsigned j = BR_STAGE; j <= NUM_STAGES - 2; j++) begin
            dst = bus.stg_dst[j*REG_W +: REG_W];
            hit = producer[j] && ((bus.id_uses_src1 && (bus.id_src1 == dst)) ||
                                  (bus.id_two_src   && (bus.id_src2 == dst)));
            if (hit && (forwarding_en ? ((j == BR_STAGE) && bus.exe_mem_read) : 1'b1))
               hazard_raw = 1'b1;
         end
      end
   end

   always_comb begin
      if (rst)                act = ACT_RESET;
      else if (bus.mem_stall) act = ACT_STALL;
      else if (branch_apply)  act = ACT_FLUSH;
      else if (hazard_raw)    act = ACT_BUBBLE;
      else                    act = ACT_RUN;
   end

   always_comb begin
      en    = '1;
      flush = '0;
      case (act)
         ACT_RESET: begin
            en    = '0;
            flush = '1;
         end
         ACT_STALL: en = '0;
         ACT_FLUSH: begin
            for (int unsigned i = ID_STG; i <= BR_STAGE; i++) flush[i] = 1'b1;
         end
         ACT_BUBBLE: begin
            en[IF_STG]      = 1'b0;
            en[ID_STG]      = 1'b0;
            flush[BR_STAGE] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q[IF_STG] <= 1'b1;
         for (int unsigned i = 1; i < NUM_STAGES; i++)
            if (en[i]) valid_q[i] <= valid_q[i-1] & ~flush[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush[BR_STAGE]) begin
         exe_src1 <= '0;
         exe_src2 <= '0;
         exe_use1 <= 1'b0;
         exe_use2 <= 1'b0;
      end else if (en[BR_STAGE]) begin
         exe_src1 <= bus.id_src1;
         exe_src2 <= bus.id_src2;
         exe_use1 <= bus.id_uses_src1;
         exe_use2 <= bus.id_two_src;
      end
   end

   pipe_fwd_match #(.NUM_STAGES(NUM_STAGES), .BR_STAGE(BR_STAGE), .REG_W(REG_W)) u_fwd1 (
      .src      (exe_src1),
      .active   (exe_use1 & forwarding_en & ~rst),
      .stg_dst  (bus.stg_dst),
      .producer (producer),
      .sel      (sel1)
   );

   pipe_fwd_match #(.NUM_STAGES(NUM_STAGES), .BR_STAGE(BR_STAGE), .REG_W(REG_W)) u_fwd2 (
      .src      (exe_src2),
      .active   (exe_use2 & forwarding_en & ~rst),
      .stg_dst  (bus.stg_dst),
      .producer (producer),
      .sel      (sel2)
   );

   assign bus.stage_en    = en;
   assign bus.stage_flush = flush;
   assign bus.stage_valid = valid_q;
   assign bus.hazard      = hazard_raw;
   assign bus.fwd_sel1    = sel1;
   assign bus.fwd_sel2    = sel2;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_q, hazard_q, flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q  <= '0;
         hazard_q <= '0;
         flush_q  <= '0;
      end else begin
         if (act == ACT_STALL)  stall_q  <= sat_inc32(stall_q);
         if (act == ACT_BUBBLE) hazard_q <= sat_inc32(hazard_q);
         if (act == ACT_FLUSH)  flush_q  <= sat_inc32(flush_q);
      end
   end

   assign stall_cnt  = stall_q;
   assign hazard_cnt = hazard_q;
   assign flush_cnt  = flush_q;
`else
   assign stall_cnt  = '0;
   assign hazard_cnt = '0;
   assign flush_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default 5/2 instance plus a 6/3 instance for forwarding.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst6, fwd_en, fwd_en6;
   logic [31:0] stall_cnt, hazard_cnt, flush_cnt;
   logic [31:0] stall6, hazard6, flush6;
   int          errors = 0;
   int          checks = 0;

   pipe_hazard_ctrl_if #(.NUM_STAGES(5), .BR_STAGE(2), .REG_W(4)) bus ();
   pipe_hazard_ctrl_if #(.NUM_STAGES(6), .BR_STAGE(3), .REG_W(4)) bus6 ();

   pipe_hazard_ctrl #(.NUM_STAGES(5), .BR_STAGE(2), .REG_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .forwarding_en (fwd_en),
      .bus           (bus),
      .stall_cnt     (stall_cnt),
      .hazard_cnt    (hazard_cnt),
      .flush_cnt     (flush_cnt)
   );

   pipe_hazard_ctrl #(.NUM_STAGES(6), .BR_STAGE(3), .REG_W(4)) dut6 (
      .clk           (clk),
      .rst           (rst6),
      .forwarding_en (fwd_en6),
      .bus           (bus6),
      .stall_cnt     (stall6),
      .hazard_cnt    (hazard6),
      .flush_cnt     (flush6)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] cexp(input int v);
      return PERF ? 64'(v) : 64'h0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_dst(input int stg, input logic [3:0] r);
      bus.stg_dst[stg*4 +: 4] = r;
   endtask

   task automatic clear_inputs();
      bus.id_src1      = '0;
      bus.id_src2      = '0;
      bus.id_two_src   = 1'b0;
      bus.id_uses_src1 = 1'b0;
      bus.stg_dst      = '0;
      bus.stg_wb_en    = '0;
      bus.exe_mem_read = 1'b0;
      bus.branch_taken = 1'b0;
      bus.mem_stall    = 1'b0;
   endtask

   task automatic chk_cnt(input string tag, input int s, input int h, input int f);
      chk({tag, "_stall"},  64'(stall_cnt),  cexp(s));
      chk({tag, "_hazard"}, 64'(hazard_cnt), cexp(h));
      chk({tag, "_flush"},  64'(flush_cnt),  cexp(f));
   endtask

   task automatic setup_load_use();
      set_dst(2, 4'd3);
      bus.stg_wb_en    = 5'b00100;
      bus.exe_mem_read = 1'b1;
      bus.id_src1      = 4'd3;
      bus.id_uses_src1 = 1'b1;
   endtask

   initial begin
      rst = 1'b1; rst6 = 1'b1; fwd_en = 1'b1; fwd_en6 = 1'b1;
      clear_inputs();
      bus6.id_src1 = '0; bus6.id_src2 = '0; bus6.id_two_src = 1'b0; bus6.id_uses_src1 = 1'b0;
      bus6.stg_dst = '0; bus6.stg_wb_en = '0; bus6.exe_mem_read = 1'b0;
      bus6.branch_taken = 1'b0; bus6.mem_stall = 1'b0;
      #1;
      chk("rst_en",     64'(bus.stage_en),    64'h00);
      chk("rst_flush",  64'(bus.stage_flush), 64'h1F);
      chk("rst_hazard", 64'(bus.hazard),      64'h0);
      chk("rst_fwd1",   64'(bus.fwd_sel1),    64'h0);
      tick(2);
      chk("rst_valid", 64'(bus.stage_valid), 64'h00);
      chk_cnt("rst", 0, 0, 0);

      // free run
      rst = 1'b0; #1;
      chk("run_en",    64'(bus.stage_en),    64'h1F);
      chk("run_flush", 64'(bus.stage_flush), 64'h00);
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk("ramp_valid", 64'(bus.stage_valid), 64'((1 << k) - 1));
         chk("ramp_en",    64'(bus.stage_en),    64'h1F);
      end

      // load-use with forwarding on
      setup_load_use(); #1;
      chk("lu_hazard", 64'(bus.hazard),      64'h1);
      chk("lu_en",     64'(bus.stage_en),    64'h1C);
      chk("lu_flush",  64'(bus.stage_flush), 64'h04);
      tick(1);
      chk("lu_valid1", 64'(bus.stage_valid), 64'h1B);
      chk_cnt("lu", 0, 1, 0);
      bus.stg_wb_en = 5'b01000; set_dst(3, 4'd3); bus.exe_mem_read = 1'b0; #1;
      chk("lu_mem_hazard", 64'(bus.hazard),   64'h0);
      chk("lu_mem_fwd1",   64'(bus.fwd_sel1), 64'h0);
      tick(1);
      chk("lu_valid2", 64'(bus.stage_valid), 64'h17);
      bus.stg_wb_en = 5'b10000; set_dst(4, 4'd3); bus.id_uses_src1 = 1'b0; #1;
      chk("lu_wb_fwd1", 64'(bus.fwd_sel1), 64'h2);
      chk("lu_wb_fwd2", 64'(bus.fwd_sel2), 64'h0);
      fwd_en = 1'b0; #1;
      chk("fwd_off_sel1", 64'(bus.fwd_sel1), 64'h0);
      fwd_en = 1'b1;
      clear_inputs();
      tick(2);
      chk("refill_valid", 64'(bus.stage_valid), 64'h1F);

      // branch with coincident load-use hazard
      setup_load_use(); bus.branch_taken = 1'b1; #1;
      chk("br_hazard", 64'(bus.hazard),      64'h0);
      chk("br_flush",  64'(bus.stage_flush), 64'h06);
      chk("br_en",     64'(bus.stage_en),    64'h1F);
      tick(1);
      chk("br_valid", 64'(bus.stage_valid), 64'h19);
      chk_cnt("br", 0, 1, 1);
      clear_inputs();
      tick(3);
      chk("br_refill", 64'(bus.stage_valid), 64'h0F);

      // memory stall holding a pending branch and hazard
      setup_load_use(); bus.branch_taken = 1'b1; bus.mem_stall = 1'b1; #1;
      for (int k = 0; k < 4; k++) begin
         chk("st_en",    64'(bus.stage_en),    64'h00);
         chk("st_flush", 64'(bus.stage_flush), 64'h00);
         chk("st_valid", 64'(bus.stage_valid), 64'h0F);
         tick(1);
      end
      chk_cnt("st", 4, 1, 1);
      bus.mem_stall = 1'b0; #1;
      chk("st_rel_en",    64'(bus.stage_en),    64'h1F);
      chk("st_rel_flush", 64'(bus.stage_flush), 64'h06);
      tick(1);
      chk("st_rel_valid", 64'(bus.stage_valid), 64'h19);
      chk_cnt("st_rel", 4, 1, 2);
      clear_inputs();
      tick(2);
      chk("st_refill", 64'(bus.stage_valid), 64'h07);

      // stall with hazard only: hazard visible, no bubble until released
      setup_load_use(); bus.mem_stall = 1'b1; #1;
      chk("sh_hazard", 64'(bus.hazard),      64'h1);
      chk("sh_en",     64'(bus.stage_en),    64'h00);
      chk("sh_flush",  64'(bus.stage_flush), 64'h00);
      tick(1);
      chk_cnt("sh", 5, 1, 2);
      bus.mem_stall = 1'b0; #1;
      chk("sh_rel_en",    64'(bus.stage_en),    64'h1C);
      chk("sh_rel_flush", 64'(bus.stage_flush), 64'h04);
      tick(1);
      chk("sh_valid", 64'(bus.stage_valid), 64'h0B);
      chk_cnt("sh_rel", 5, 2, 2);
      clear_inputs();
      tick(2);
      chk("sh_refill", 64'(bus.stage_valid), 64'h0F);

      // forwarding disabled: ALU producer in MEM stalls
      fwd_en = 1'b0; set_dst(3, 4'd5); bus.stg_wb_en = 5'b01000;
      bus.id_src2 = 4'd5; bus.id_two_src = 1'b1; #1;
      chk("nf_hazard", 64'(bus.hazard),   64'h1);
      chk("nf_en",     64'(bus.stage_en), 64'h1C);
      bus.id_two_src = 1'b0; #1;
      chk("nf_unused_src2", 64'(bus.hazard), 64'h0);
      bus.id_two_src = 1'b1; fwd_en = 1'b1; #1;
      chk("fw_hazard", 64'(bus.hazard), 64'h0);
      tick(1);
      chk("fw_valid", 64'(bus.stage_valid), 64'h1F);
      set_dst(3, 4'd0); set_dst(4, 4'd5); bus.stg_wb_en = 5'b10000; fwd_en = 1'b0; #1;
      chk("nf_wb_hazard", 64'(bus.hazard), 64'h0);
      chk_cnt("pre_rst", 5, 2, 2);

      // reset mid-operation
      rst = 1'b1; #1;
      chk("mrst_en",     64'(bus.stage_en),    64'h00);
      chk("mrst_flush",  64'(bus.stage_flush), 64'h1F);
      tick(1);
      chk("mrst_valid", 64'(bus.stage_valid), 64'h00);
      chk_cnt("mrst", 0, 0, 0);
      rst = 1'b0; fwd_en = 1'b1; clear_inputs();

      // 6-stage / EXE=3 instance: youngest producer wins
      bus6.id_src1 = 4'd7; bus6.id_uses_src1 = 1'b1;
      bus6.stg_dst = '0;
      bus6.stg_dst[4*4 +: 4] = 4'd7;
      bus6.stg_dst[5*4 +: 4] = 4'd7;
      bus6.stg_wb_en = 6'b110000;
      rst6 = 1'b0;
      tick(6);
      chk("p6_valid",  64'(bus6.stage_valid), 64'h3F);
      chk("p6_hazard", 64'(bus6.hazard),      64'h0);
      chk("p6_fwd1",   64'(bus6.fwd_sel1),    64'h1);
      chk("p6_fwd2",   64'(bus6.fwd_sel2),    64'h0);
      bus6.stg_wb_en = 6'b100000; #1;
      chk("p6_fwd1_wb", 64'(bus6.fwd_sel1), 64'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control block for the ARM core. It replaces the separate freeze, flush, hazard and forwarding glue with a single unit.
- Tracks a valid bit per stage and generates per-stage register enables and flushes.
- Detects RAW hazards at ID and produces EXE operand forwarding selects for any pipeline depth and branch-resolve position.
- Sits beside the stage registers in the top level. It is driven by ID decode, per-stage dst/wb_en and the cache/SRAM memory stall.

Parameters:
- NUM_STAGES, 5, number of pipeline stages; stage 0 = IF, 1 = ID, NUM_STAGES-1 = WB; legal range >= 4
- BR_STAGE, 2, stage that resolves branches and consumes forwarded operands (EXE); legal range 2..NUM_STAGES-2
- REG_W, 4, register-index width
- FWD_W, $clog2(NUM_STAGES-BR_STAGE), forwarding-select width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- forwarding_en  in  1  1 = forwarding active; 0 = stall on every in-flight RAW
- id_src1  in  REG_W  Rn of the instruction in ID
- id_src2  in  REG_W  second source of the instruction in ID
- id_two_src  in  1  id_src2 is used
- id_uses_src1  in  1  id_src1 is used
- stg_dst  in  NUM_STAGES*REG_W  destination per stage; slice i = stage i
- stg_wb_en  in  NUM_STAGES  writeback enable per stage
- exe_mem_read  in  1  instruction in BR_STAGE is a load
- branch_taken  in  1  taken branch resolving in BR_STAGE
- mem_stall  in  1  cache/SRAM not ready
- stage_en  out  NUM_STAGES  register-load enable for stage i's input register (bit 0 = PC)
- stage_flush  out  NUM_STAGES  clear stage i's input register to a bubble
- stage_valid  out  NUM_STAGES  registered valid per stage
- hazard  out  1  ID stall (combinational)
- fwd_sel1  out  FWD_W  EXE src1 select: 0 = regfile; k = stage BR_STAGE+k
- fwd_sel2  out  FWD_W  EXE src2 select, same encoding
- stall_cnt  out  32  memory-stall cycles
- hazard_cnt  out  32  hazard bubbles
- flush_cnt  out  32  branch flushes

Behaviour:
- **Reset (rst=1 on a clock edge):**
  - stage_valid = 0
  - EXE shadow regs (exe_src1, exe_src2, exe_use1, exe_use2) = 0
  - counters = 0
- **While rst is high:** stage_en = 0, stage_flush = all 1, hazard = 0, fwd_sel = 0.
- **Reset mid-operation:** all in-flight state is dropped in that cycle.
- Stage i counts as a producer only when stage_valid[i] & stg_wb_en[i].
- **Hazard:** raised only when stage_valid[1] and no branch_taken. A used ID source equal to dst of a producer stage j sets hazard when either:
  - forwarding_en=1, j = BR_STAGE and exe_mem_read=1 (load-use)
  - forwarding_en=0, BR_STAGE <= j <= NUM_STAGES-2
- **Priority:** mem_stall > branch_taken > hazard.
  - mem_stall: stage_en = 0, stage_flush = 0, all state holds. hazard is still computed but does not bubble.
  - branch_taken (valid in BR_STAGE, no stall): stage_en = all 1; stage_flush[1..BR_STAGE] = 1. Next cycle, stage_valid[1..BR_STAGE] = 0 and stage_valid[0] = 1. Any hazard in the same cycle is ignored.
  - hazard (no stall, no branch): stage_en[0] = stage_en[1] = 0; stage_en[2..] = 1; stage_flush[BR_STAGE] = 1, which inserts a bubble.
  - otherwise: stage_en = all 1, stage_flush = 0.
- **Valid propagation:**
  - stage_valid[0] goes to 1 the cycle after reset and stays 1.
  - For i >= 1, when stage_en[i]: stage_valid[i] <= stage_valid[i-1] & ~stage_flush[i].
- **EXE shadow regs:**
  - Load from id_src*/id_uses_src1/id_two_src when stage_en[BR_STAGE] & ~stage_flush[BR_STAGE].
  - Cleared when stage_flush[BR_STAGE].
- **Forwarding (combinational):**
  - Source is the youngest valid producer in stages BR_STAGE+1..NUM_STAGES-1 whose dst equals the shadow source; fwd_sel = stage - BR_STAGE.
  - fwd_sel = 0 when the source is unused, forwarding_en = 0, or there is no match.
  - The final (WB) stage is included.
- **Counters:**
  - stall_cnt: +1 per cycle with mem_stall.
  - hazard_cnt: +1 per bubble inserted.
  - flush_cnt: +1 per applied branch flush.
  - All saturate at 0xFFFFFFFF.

Optional Feature:
- PIPE_PERF_CNT_EN defined: the three counters exist as specified.
- Not defined: no counter flops; stall_cnt, hazard_cnt and flush_cnt are tied to 0.

Decomposition:
- Package arm_pipe_pkg holds:
  - default stage index constants (IF_STG=0, ID_STG=1, EXE_STG=2)
  - the FWD_REGFILE=0 constant
  - a sat_inc32 function
- One natural sub-module: pipe_fwd_match, a parametrised youngest-match priority encoder. It is instantiated twice, once per EXE source.

Test Plan:
- **Reset then free-run:** reset, then no hazards for 5 cycles → stage_valid = 5'b11111 on cycle 5; stage_en = all 1.
- **Load-use, forwarding on:** EXE holds a load to r3 (wb_en=1); ID src1=r3 → hazard=1; stage_en = 5'b11100; stage_flush[2]=1. Next cycle, stage_valid[2]=0 and the MEM stage holds the load. One cycle later, fwd_sel1=1 (MEM) is replaced by hazard-free issue and fwd_sel1=2 (WB) selects the load's writeback.
- **Branch with coincident hazard:** branch_taken=1 and hazard conditions in the same cycle → stage_flush = 5'b00110; hazard=0; flush_cnt increments by 1; stage_valid[1:2] = 0 next cycle.
- **Mem stall during hazard and branch:** mem_stall=1 for 4 cycles with branch_taken=1 → stage_en=0 and the flush is deferred. stall_cnt=4 after the stall. The flush is applied on the first non-stall cycle.
- **Forwarding off:** forwarding_en=0, ALU write to r5 in MEM, ID src2=r5 with two_src=1 → hazard=1. The same case with forwarding_en=1 gives hazard=0.
- **Parameter sweep:** NUM_STAGES=6, BR_STAGE=3, producer r7 in stages 4 and 5 → fwd_sel1=1 (youngest).
